instr_encoder: RTL and testbench
================================

# instr_encoder

Sequential instruction assembler and instruction-memory writer for the single-cycle RISC-V CPU. It accepts field-level instruction requests over a valid/ready handshake and encodes them into 32-bit words for the four formats the main control decoder recognises: R-format, ld, sd and beq. It buffers the words in a small FIFO and writes them into instruction memory at an auto-incrementing address, honouring memory backpressure. Testbenches and the program loader use it to produce programs whose opcodes the decoder consumes.

## Interface
- DEPTH, 4: FIFO entries (power of two, ≥2).
- ADDR_W, 8: instruction-memory word-address width.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  request present.
- in_ready  out  1  request can be accepted this cycle.
- in_kind  in  2  0 = R-format, 1 = ld, 2 = sd, 3 = beq.
- rd, rs1, rs2  in  5 each  register fields.
- funct3  in  3  funct3 field.
- funct7  in  7  funct7 field (R-format only).
- imm  in  13  immediate; ld/sd use imm[11:0], beq uses imm[12:1], imm[0] ignored.
- base_addr  in  ADDR_W  start address.
- load_base  in  1  pulse; loads base_addr into the write pointer.
- mem_we  out  1  write request (valid).
- mem_ready  in  1  memory accepts the write this cycle.
- mem_addr  out  ADDR_W  word address of the current write.
- mem_wdata  out  32  encoded instruction.
- level  out  clog2(DEPTH+1)  FIFO occupancy.

## Operation
- Accept: the block accepts a request when in_valid && in_ready. It encodes the request combinationally and pushes it into the FIFO on that edge.
- Encodings. Unused fields are ignored.
  - R: {funct7, rs2, rs1, funct3, rd, 7'b0110011}
  - ld: {imm[11:0], rs1, funct3, rd, 7'b0000011}
  - sd: {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011}
  - beq: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011}
- in_ready = (level < DEPTH). It is registered-state only and has no combinational path from mem_ready. When the FIFO is full, the block refuses input even if a pop happens in the same cycle.
- Output:
  - mem_we = FIFO non-empty, and mem_wdata = FIFO head.
  - A write completes on mem_we && mem_ready. On completion the head pops and mem_addr increments by 1, wrapping modulo 2^ADDR_W.
- Stability: while mem_we && !mem_ready, mem_wdata and mem_addr hold constant.
- Simultaneous push and pop with 0 < level < DEPTH: level unchanged, order preserved.
- load_base: mem_addr = base_addr from the next cycle. If a write completes in the same cycle, load_base wins and the completed write used the old address. load_base never affects FIFO contents.
- Internal pointers wrap modulo DEPTH.

## Timing
- Reset (asynchronous assert, released synchronously to clk by the system):
  - mem_we = 0, mem_addr = 0, mem_wdata = 0, level = 0, in_ready = 1 after release.
  - in_ready = 0 while rst_n is low.
- Latency: a request accepted at edge N appears on mem_we/mem_wdata in the cycle after edge N. The earliest memory write completes at edge N+1.
- Throughput: one accept and one write per cycle sustained when mem_ready = 1.
- Reset mid-operation: FIFO contents are discarded immediately and no further mem_we is issued. The write pointer returns to 0.
- mem_wdata shows 0 when the FIFO is empty.

## Test plan
- R add x3,x1,x2 (rd=3, rs1=1, rs2=2, f3=0, f7=0), mem_ready=1, base 0 -> one cycle later mem_we=1, mem_addr=0x00, mem_wdata=0x002081B3; mem_addr=0x01 after the write.
- ld x5,8(x2) then sd x5,16(x2) (f3=3) back-to-back -> writes 0x00813283 at addr 0 and 0x00513823 at addr 1 on consecutive cycles.
- beq x1,x2,-8 (imm=13'h1FF8, f3=0) -> mem_wdata=0xFE208CE3.
- mem_ready=0, five requests offered -> 4 accepted, in_ready=0 with level=4, mem_wdata held at the first word. Release mem_ready -> 4 writes at consecutive addresses, then the 5th is accepted and written.
- load_base with base_addr=0xFE, then 3 writes -> addresses 0xFE, 0xFF, 0x00. load_base in the same cycle as a completed write -> next address = base_addr.
- rst_n low with level=2 and mem_ready=0 -> mem_we=0, level=0, mem_addr=0 immediately. After release there are no stale writes.

Source files
------------

// File: rtl/instr_encoder.sv
// Field-level RISC-V instruction assembler (R/ld/sd/beq) feeding a small FIFO
// that writes encoded words into instruction memory at an auto-incrementing address.
module instr_encoder #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 8,
  localparam int unsigned LVL_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_kind,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [12:0]       imm,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              load_base,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [LVL_W-1:0]  level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    KIND_R   = 2'd0,
    KIND_LD  = 2'd1,
    KIND_SD  = 2'd2,
    KIND_BEQ = 2'd3
  } kind_e;

  kind_e             kind;
  logic [31:0]       enc;
  logic              push;
  logic              pop;
  logic              empty;
  logic [31:0]       fifo_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              unused_imm0;

  // beq immediates are halfword offsets, so bit 0 carries no information.
  assign unused_imm0 = imm[0];
  assign kind        = kind_e'(in_kind);

  always_comb begin
    enc = '0;
    unique case (kind)
      KIND_R:   enc = {funct7, rs2, rs1, funct3, rd, 7'b0110011};
      KIND_LD:  enc = {imm[11:0], rs1, funct3, rd, 7'b0000011};
      KIND_SD:  enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011};
      KIND_BEQ: enc = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011};
    endcase
  end

  assign empty     = (level_q == '0);
  assign in_ready  = rst_n && (level_q < LVL_W'(DEPTH));
  assign mem_we    = !empty;
  assign mem_wdata = empty ? '0 : fifo_q[rd_ptr_q];
  assign mem_addr  = addr_q;
  assign level     = level_q;

  assign push = in_valid && in_ready;
  assign pop  = mem_we && mem_ready;

  always_comb begin
    wr_ptr_d = push ? PTR_W'(wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d = pop  ? PTR_W'(rd_ptr_q + 1'b1) : rd_ptr_q;
    level_d  = level_q;
    unique case ({push, pop})
      2'b10:   level_d = LVL_W'(level_q + 1'b1);
      2'b01:   level_d = LVL_W'(level_q - 1'b1);
      default: level_d = level_q;
    endcase
    // A base reload overrides the post-write increment.
    addr_d = addr_q;
    if (load_base)
      addr_d = base_addr;
    else if (pop)
      addr_d = ADDR_W'(addr_q + 1'b1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      addr_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      addr_q   <= addr_d;
    end
  end

  // Storage needs no reset: the read port is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (push)
      fifo_q[wr_ptr_q] <= enc;
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder: encodings, backpressure,
// base reload, address wrap and asynchronous reset.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_kind;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [12:0] imm;
  logic [7:0]  base_addr;
  logic        load_base;
  logic        mem_we;
  logic        mem_ready;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  level;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [31:0] bp_words [5] = '{32'h000000B3, 32'h00000133, 32'h000001B3,
                                32'h00000233, 32'h000002B3};

  instr_encoder #(.DEPTH(4), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7(funct7), .imm(imm), .base_addr(base_addr), .load_base(load_base),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .level(level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic req(input logic [1:0] k, input logic [4:0] d, input logic [4:0] s1,
                     input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                     input logic [12:0] im);
    in_valid = 1'b1;
    in_kind  = k;
    rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_kind = '0; rd = '0; rs1 = '0; rs2 = '0;
    funct3 = '0; funct7 = '0; imm = '0; base_addr = '0; load_base = 1'b0; mem_ready = 1'b1;
    step(); step();
    check("rst_in_ready_low", 32'(in_ready), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;
    #1 check("rel_in_ready", 32'(in_ready), 32'd1);

    // R add x3,x1,x2
    step();
    req(2'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0);
    step();
    in_valid = 1'b0;
    check("r_we", 32'(mem_we), 32'd1);
    check("r_addr", 32'(mem_addr), 32'h00);
    check("r_wdata", mem_wdata, 32'h002081B3);
    check("r_level", 32'(level), 32'd1);
    step();
    check("r_done_we", 32'(mem_we), 32'd0);
    check("r_done_addr", 32'(mem_addr), 32'h01);
    check("r_empty_wdata", mem_wdata, 32'd0);

    // ld/sd back-to-back, base reloaded to 0 alongside the first push
    load_base = 1'b1; base_addr = 8'h00;
    req(2'd1, 5'd5, 5'd2, 5'd0, 3'd3, 7'd0, 13'd8);
    step();
    load_base = 1'b0;
    check("ld_addr", 32'(mem_addr), 32'h00);
    check("ld_wdata", mem_wdata, 32'h00813283);
    req(2'd2, 5'd0, 5'd2, 5'd5, 3'd3, 7'd0, 13'd16);
    step();
    in_valid = 1'b0;
    check("sd_addr", 32'(mem_addr), 32'h01);
    check("sd_wdata", mem_wdata, 32'h00513823);
    check("sd_level", 32'(level), 32'd1);
    step();
    check("sd_done_we", 32'(mem_we), 32'd0);
    check("sd_done_addr", 32'(mem_addr), 32'h02);

    // beq x1,x2,-8
    req(2'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'h1FF8);
    step();
    in_valid = 1'b0;
    check("beq_wdata", mem_wdata, 32'hFE208CE3);
    check("beq_addr", 32'(mem_addr), 32'h02);
    step();
    check("beq_done_addr", 32'(mem_addr), 32'h03);

    // Backpressure: five offered, four fit
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req(2'd0, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 13'd0);
      step();
      check("bp_fill_level", 32'(level), 32'(i + 1));
      check("bp_fill_head", mem_wdata, bp_words[0]);
    end
    req(2'd0, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 13'd0);
    check("bp_full_ready", 32'(in_ready), 32'd0);
    step();
    check("bp_hold_level", 32'(level), 32'd4);
    check("bp_hold_wdata", mem_wdata, bp_words[0]);
    check("bp_hold_addr", 32'(mem_addr), 32'h03);
    mem_ready = 1'b1;
    step();
    // Full at the edge: pop happened, the 5th request was refused.
    check("bp_refused_level", 32'(level), 32'd3);
    check("bp_after_pop_wdata", mem_wdata, bp_words[1]);
    check("bp_after_pop_addr", 32'(mem_addr), 32'h04);
    step();
    in_valid = 1'b0;
    check("bp_pushpop_level", 32'(level), 32'd3);
    for (int i = 2; i < 5; i++) begin
      check("bp_drain_we", 32'(mem_we), 32'd1);
      check("bp_drain_wdata", mem_wdata, bp_words[i]);
      check("bp_drain_addr", 32'(mem_addr), 32'(3 + i));
      step();
    end
    check("bp_empty_we", 32'(mem_we), 32'd0);
    check("bp_empty_addr", 32'(mem_addr), 32'h08);

    // Base 0xFE with wrap, then reload concurrent with a completed write
    load_base = 1'b1; base_addr = 8'hFE;
    req(2'd0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 13'd0);
    step();
    load_base = 1'b0;
    check("wrap_a_addr", 32'(mem_addr), 32'hFE);
    check("wrap_a_wdata", mem_wdata, bp_words[0]);
    req(2'd0, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 13'd0);
    step();
    check("wrap_b_addr", 32'(mem_addr), 32'hFF);
    check("wrap_b_wdata", mem_wdata, bp_words[1]);
    req(2'd0, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 13'd0);
    step();
    in_valid = 1'b0;
    check("wrap_c_addr", 32'(mem_addr), 32'h00);
    check("wrap_c_wdata", mem_wdata, bp_words[2]);
    check("wrap_c_we", 32'(mem_we), 32'd1);
    load_base = 1'b1; base_addr = 8'h40;
    step();
    load_base = 1'b0;
    check("lb_win_addr", 32'(mem_addr), 32'h40);
    check("lb_win_level", 32'(level), 32'd0);

    // Asynchronous reset with two words stuck behind backpressure
    mem_ready = 1'b0;
    req(2'd0, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 13'd0);
    step();
    req(2'd0, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 13'd0);
    step();
    in_valid = 1'b0;
    check("pre_rst_level", 32'(level), 32'd2);
    check("pre_rst_wdata", mem_wdata, bp_words[3]);
    #2 rst_n = 1'b0;
    #1;
    check("arst_we", 32'(mem_we), 32'd0);
    check("arst_level", 32'(level), 32'd0);
    check("arst_addr", 32'(mem_addr), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd0);
    check("arst_wdata", mem_wdata, 32'd0);
    step();
    rst_n = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_no_we", 32'(mem_we), 32'd0);
      check("post_rst_addr", 32'(mem_addr), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
